// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline definitions: opcodes, controller states and
// instruction field helpers used by the hazard controller.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    function automatic logic [5:0] f_opcode(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ins);
        return ins[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ins);
        return ins[20:16];
    endfunction

    function automatic logic f_is_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    // Only the jump forms ignore the rs field.
    function automatic logic f_reads_rs(input logic [5:0] op);
        return (op != OP_J) && (op != OP_JAL);
    endfunction

    function automatic logic f_reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Flags an instruction in ID that reads the destination of a load sitting in EX.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic [31:0] id_ins,
    input  logic [31:0] ex_ins,
    output logic        hazard
);

    logic [5:0] w_op_id;
    logic [5:0] w_op_ex;
    logic [4:0] w_rt_ex;
    logic       w_ex_is_load;
    logic       w_rs_match;
    logic       w_rt_match;
    logic       w_unused;

    assign w_op_id      = f_opcode(id_ins);
    assign w_op_ex      = f_opcode(ex_ins);
    assign w_rt_ex      = f_rt(ex_ins);
    assign w_ex_is_load = (w_op_ex == OP_LW);

    assign w_rs_match = f_reads_rs(w_op_id) && (f_rs(id_ins) == w_rt_ex);
    assign w_rt_match = f_reads_rt(w_op_id) && (f_rt(id_ins) == w_rt_ex);

    // $0 is never a real dependency.
    assign hazard = w_ex_is_load && (w_rt_ex != 5'd0) && (w_rs_match || w_rt_match);

    assign w_unused = ^{id_ins[15:0], ex_ins[25:21], ex_ins[15:0]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: sequences the data-memory handshake, freezes the
// pipeline on waits/timeouts, and resolves branch squash and load-use bubbles.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_ins,
    input  logic [31:0] ex_ins,
    input  logic [31:0] mem_ins,
    input  logic        branch_taken,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        hold_pc,
    output logic        hold_ifid,
    output logic        hold_idex,
    output logic        hold_exmem,
    output logic        flush_ifid,
    output logic        bubble_idex,
    output logic        bubble_memwb,
    output logic        mem_err,
    output state_t      dbg_state
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;

    logic [5:0] w_mem_op;
    logic       w_is_mem;
    logic       w_is_store;
    logic       w_hazard;
    logic       w_freeze;
    logic       w_unused_mem;

    assign w_mem_op     = f_opcode(mem_ins);
    assign w_is_mem     = f_is_mem(w_mem_op);
    assign w_is_store   = (w_mem_op == OP_SW);
    assign w_unused_mem = ^mem_ins[25:0];

    load_use_detect u_load_use (
        .id_ins (id_ins),
        .ex_ins (ex_ins),
        .hazard (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_is_mem && !dmem_ready) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CW'(1);
                        r_we    <= w_is_store;
                    end
                end
                ST_WAIT: begin
                    // A ready on the last allowed cycle still completes.
                    if (dmem_ready) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else if (r_cnt >= CNT_MAX) begin
                        r_state <= ST_ERR;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        hold_pc      = 1'b0;
        hold_ifid    = 1'b0;
        hold_idex    = 1'b0;
        hold_exmem   = 1'b0;
        flush_ifid   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_memwb = 1'b0;
        mem_err      = 1'b0;
        w_freeze     = 1'b0;
        if (reset) begin
            case (r_state)
                ST_RUN: begin
                    dmem_req = w_is_mem;
                    dmem_we  = w_is_mem && w_is_store;
                    w_freeze = w_is_mem && !dmem_ready;
                end
                ST_WAIT: begin
                    dmem_req = 1'b1;
                    dmem_we  = r_we;
                    w_freeze = !dmem_ready;
                end
                ST_ERR: begin
                    mem_err  = 1'b1;
                    w_freeze = 1'b1;
                end
                default: begin
                    w_freeze = 1'b0;
                end
            endcase

            // Freeze outranks branch squash, which outranks the load-use bubble.
            if (w_freeze) begin
                hold_pc      = 1'b1;
                hold_ifid    = 1'b1;
                hold_idex    = 1'b1;
                hold_exmem   = 1'b1;
                bubble_memwb = 1'b1;
            end else if (branch_taken) begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else if (w_hazard) begin
                hold_pc     = 1'b1;
                hold_ifid   = 1'b1;
                bubble_idex = 1'b1;
            end
        end
    end

    assign dbg_state = reset ? r_state : ST_RUN;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle stimulus rows push the
// expected control vector, which is popped and compared at the falling edge.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_LW8      = 32'h8D08_0000;
    localparam logic [31:0] I_LW0      = 32'h8D00_0000;
    localparam logic [31:0] I_SW8      = 32'hAC28_0000;
    localparam logic [31:0] I_ADD_R8   = 32'h0101_4820;
    localparam logic [31:0] I_ADD_R0   = 32'h0001_4820;
    localparam logic [31:0] I_SW_RT8   = 32'hAC48_0004;
    localparam logic [31:0] I_BEQ_R8   = 32'h1068_0000;
    localparam logic [31:0] I_J        = 32'h0900_0000;
    localparam logic [31:0] I_ADDI_RT8 = 32'h2048_0001;
    localparam logic [31:0] I_LW_RS8   = 32'h8D02_0000;
    localparam logic [31:0] I_LW_RT8   = 32'h8C68_0000;

    // {req, we, hold_pc, hold_ifid, hold_idex, hold_exmem, flush_ifid, bubble_idex, bubble_memwb, mem_err}
    localparam logic [9:0] C_NONE = 10'b00_0000_0000;
    localparam logic [9:0] C_FRZ  = 10'b00_1111_0010;
    localparam logic [9:0] C_LU   = 10'b00_1100_0100;
    localparam logic [9:0] C_BR   = 10'b00_0000_1100;
    localparam logic [9:0] C_RD   = 10'b10_0000_0000;
    localparam logic [9:0] C_WR   = 10'b11_0000_0000;
    localparam logic [9:0] C_ERR  = 10'b00_1111_0011;

    typedef struct packed {
        logic        rst;
        logic [31:0] id;
        logic [31:0] ex;
        logic [31:0] mem;
        logic        br;
        logic        rdy;
        logic [11:0] exp;
    } row_t;

    logic        clk;
    logic        reset;
    logic [31:0] id_ins;
    logic [31:0] ex_ins;
    logic [31:0] mem_ins;
    logic        branch_taken;
    logic        dmem_ready;

    logic   dmem_req, dmem_we, hold_pc, hold_ifid, hold_idex, hold_exmem;
    logic   flush_ifid, bubble_idex, bubble_memwb, mem_err;
    state_t dbg_state;

    logic   dmem_req1, dmem_we1, hold_pc1, hold_ifid1, hold_idex1, hold_exmem1;
    logic   flush_ifid1, bubble_idex1, bubble_memwb1, mem_err1;
    state_t dbg_state1;

    logic [11:0] obs;
    logic [11:0] obs1;
    logic [11:0] exp_q[$];
    int          n_assert;
    int          n_fail;

    pipe_hazard_ctrl #(.TIMEOUT(4)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .id_ins       (id_ins),
        .ex_ins       (ex_ins),
        .mem_ins      (mem_ins),
        .branch_taken (branch_taken),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .hold_pc      (hold_pc),
        .hold_ifid    (hold_ifid),
        .hold_idex    (hold_idex),
        .hold_exmem   (hold_exmem),
        .flush_ifid   (flush_ifid),
        .bubble_idex  (bubble_idex),
        .bubble_memwb (bubble_memwb),
        .mem_err      (mem_err),
        .dbg_state    (dbg_state)
    );

    pipe_hazard_ctrl #(.TIMEOUT(1)) u_dut_t1 (
        .clk          (clk),
        .reset        (reset),
        .id_ins       (id_ins),
        .ex_ins       (ex_ins),
        .mem_ins      (mem_ins),
        .branch_taken (branch_taken),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req1),
        .dmem_we      (dmem_we1),
        .hold_pc      (hold_pc1),
        .hold_ifid    (hold_ifid1),
        .hold_idex    (hold_idex1),
        .hold_exmem   (hold_exmem1),
        .flush_ifid   (flush_ifid1),
        .bubble_idex  (bubble_idex1),
        .bubble_memwb (bubble_memwb1),
        .mem_err      (mem_err1),
        .dbg_state    (dbg_state1)
    );

    assign obs  = {dbg_state, dmem_req, dmem_we, hold_pc, hold_ifid, hold_idex, hold_exmem,
                   flush_ifid, bubble_idex, bubble_memwb, mem_err};
    assign obs1 = {dbg_state1, dmem_req1, dmem_we1, hold_pc1, hold_ifid1, hold_idex1, hold_exmem1,
                   flush_ifid1, bubble_idex1, bubble_memwb1, mem_err1};

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic row_t rw(input logic rst, input logic [31:0] id, input logic [31:0] ex,
                                input logic [31:0] mem, input logic br, input logic rdy,
                                input state_t st, input logic [9:0] ctl);
        row_t r;
        r.rst = rst;
        r.id  = id;
        r.ex  = ex;
        r.mem = mem;
        r.br  = br;
        r.rdy = rdy;
        r.exp = {st, ctl};
        return r;
    endfunction

    // Driver: apply one cycle of inputs and record what the outputs must be.
    task automatic drive_row(input row_t r);
        reset        = r.rst;
        id_ins       = r.id;
        ex_ins       = r.ex;
        mem_ins      = r.mem;
        branch_taken = r.br;
        dmem_ready   = r.rdy;
        exp_q.push_back(r.exp);
    endtask

    task automatic test_reset();
        row_t        rows[$];
        logic [11:0] e;
        rows.push_back(rw(1'b0, I_ADD_R8, I_LW8, I_LW8, 1'b1, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b0, I_ADD_R8, I_LW8, I_SW8, 1'b1, 1'b1, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset row %0d: got %b required %b", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_wait();
        row_t        rows[$];
        logic [11:0] e;
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_SW8, 1'b0, 1'b1, ST_RUN, C_WR));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b1, ST_RUN, C_RD));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b1, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL zero_wait row %0d: got %b required %b", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Memory op whose ready arrives n cycles after the request (1..TIMEOUT).
    task automatic test_mem_wait(input string name, input logic [31:0] ins, input int n,
                                 input logic br);
        row_t        rows[$];
        logic [11:0] e;
        logic [9:0]  req;
        logic [5:0]  op;
        op  = ins[31:26];
        req = (op == 6'h2B) ? C_WR : C_RD;
        rows.push_back(rw(1'b1, I_NOP, I_NOP, ins, br, 1'b0, ST_RUN, req | C_FRZ));
        for (int k = 1; k < n; k++)
            rows.push_back(rw(1'b1, I_NOP, I_NOP, ins, br, 1'b0, ST_WAIT, req | C_FRZ));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, ins, br, 1'b1, ST_WAIT, req | (br ? C_BR : C_NONE)));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s (wait %0d) row %0d: got %b required %b", name, n, i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        row_t        rows[$];
        logic [11:0] e;
        rows.push_back(rw(1'b1, I_ADD_R8,   I_LW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_LU));
        rows.push_back(rw(1'b1, I_ADD_R8,   I_NOP, I_LW8, 1'b0, 1'b1, ST_RUN, C_RD));
        rows.push_back(rw(1'b1, I_ADD_R0,   I_LW0, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_SW_RT8,   I_LW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_LU));
        rows.push_back(rw(1'b1, I_BEQ_R8,   I_LW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_LU));
        rows.push_back(rw(1'b1, I_J,        I_LW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_ADDI_RT8, I_LW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_LW_RS8,   I_LW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_LU));
        rows.push_back(rw(1'b1, I_LW_RT8,   I_LW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_ADD_R8,   I_SW8, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        // Hazard is masked while frozen and reappears in the release cycle.
        rows.push_back(rw(1'b1, I_ADD_R8,   I_LW8, I_LW8, 1'b0, 1'b0, ST_RUN, C_RD | C_FRZ));
        rows.push_back(rw(1'b1, I_ADD_R8,   I_LW8, I_LW8, 1'b0, 1'b1, ST_WAIT, C_RD | C_LU));
        rows.push_back(rw(1'b1, I_NOP,      I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_use row %0d: got %b required %b", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch();
        row_t        rows[$];
        logic [11:0] e;
        rows.push_back(rw(1'b1, I_ADD_R8, I_LW8, I_NOP, 1'b1, 1'b0, ST_RUN, C_BR));
        rows.push_back(rw(1'b1, I_NOP,    I_NOP, I_NOP, 1'b1, 1'b0, ST_RUN, C_BR));
        rows.push_back(rw(1'b1, I_NOP,    I_NOP, I_SW8, 1'b1, 1'b1, ST_RUN, C_WR | C_BR));
        rows.push_back(rw(1'b1, I_NOP,    I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL branch row %0d: got %b required %b", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // TIMEOUT=4: four WAIT cycles without ready, then ERR until reset.
    task automatic test_timeout();
        row_t        rows[$];
        logic [11:0] e;
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_RUN, C_RD | C_FRZ));
        for (int k = 0; k < 4; k++)
            rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_WAIT, C_RD | C_FRZ));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_ERR, C_ERR));
        rows.push_back(rw(1'b1, I_ADD_R8, I_LW8, I_LW8, 1'b1, 1'b1, ST_ERR, C_ERR));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_ERR, C_ERR));
        rows.push_back(rw(1'b0, I_NOP, I_NOP, I_LW8, 1'b1, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL timeout row %0d: got %b required %b", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        row_t        rows[$];
        logic [11:0] e;
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_SW8, 1'b0, 1'b0, ST_RUN, C_WR | C_FRZ));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_SW8, 1'b0, 1'b0, ST_WAIT, C_WR | C_FRZ));
        rows.push_back(rw(1'b0, I_NOP, I_NOP, I_SW8, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_RUN, C_RD | C_FRZ));
        for (int k = 0; k < 4; k++)
            rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_WAIT, C_RD | C_FRZ));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_ERR, C_ERR));
        rows.push_back(rw(1'b0, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_wait row %0d: got %b required %b", i, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // TIMEOUT=1 instance: ERR right after the first WAIT cycle without ready.
    task automatic test_timeout_one();
        row_t        rows[$];
        logic [11:0] e;
        rows.push_back(rw(1'b0, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_RUN, C_RD | C_FRZ));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b0, ST_WAIT, C_RD | C_FRZ));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_LW8, 1'b0, 1'b1, ST_ERR, C_ERR));
        rows.push_back(rw(1'b0, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        rows.push_back(rw(1'b1, I_NOP, I_NOP, I_NOP, 1'b0, 1'b0, ST_RUN, C_NONE));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            n_assert++;
            if (obs1 !== e) begin
                n_fail++;
                $display("FAIL timeout_one row %0d: got %b required %b", i, obs1, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        id_ins       = I_NOP;
        ex_ins       = I_NOP;
        mem_ins      = I_NOP;
        branch_taken = 1'b0;
        dmem_ready   = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_zero_wait();
        test_mem_wait("lw_wait3", I_LW8, 3, 1'b0);
        test_mem_wait("sw_wait_rand", I_SW8, int'($urandom_range(1, 4)), 1'b0);
        test_mem_wait("lw_wait_max", I_LW8, 4, 1'b0);
        test_mem_wait("branch_in_freeze", I_LW8, int'($urandom_range(1, 4)), 1'b1);
        test_load_use();
        test_branch();
        test_timeout();
        test_reset_mid_wait();
        test_timeout_one();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. It sequences the EX/MEM register and the multi-cycle data-memory handshake, detects load-use hazards between ID and EX, and squashes wrong-path instructions on taken branches. It drives per-register hold and bubble enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, which are otherwise free-running capture registers.

## Interface
- TIMEOUT, 255: maximum WAIT-state cycles before a memory access is declared failed (range 1..65535).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low.
- id_ins  in  32  instruction currently in IF/ID.
- ex_ins  in  32  instruction currently in ID/EX.
- mem_ins  in  32  instruction currently in EX/MEM.
- branch_taken  in  1  resolved taken branch/jump in EX.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  data memory access request.
- dmem_we  out  1  write enable; qualifies dmem_req.
- hold_pc  out  1  PC keeps its value.
- hold_ifid  out  1  IF/ID keeps its value.
- hold_idex  out  1  ID/EX keeps its value.
- hold_exmem  out  1  EX/MEM keeps its value.
- flush_ifid  out  1  IF/ID loads zero (nop).
- bubble_idex  out  1  ID/EX loads zero.
- bubble_memwb  out  1  MEM/WB loads zero.
- mem_err  out  1  sticky timeout flag.

## Operation
- Opcode is ins[31:26]. A memory op is lw (0x23) or sw (0x2B). Register fields: rs = [25:21], rt = [20:16].
- States: RUN, WAIT, ERR. A wait counter has width clog2(TIMEOUT+1).
- RUN:
  - mem_ins is a memory op: dmem_req=1, dmem_we=(opcode==0x2B).
    - dmem_ready=1: the access completes and the pipeline advances.
    - dmem_ready=0: go to WAIT with counter=1, and freeze this cycle.
  - No memory op: dmem_req=0.
- WAIT:
  - dmem_req and dmem_we are held at their RUN values. Freeze.
  - dmem_ready=1: go to RUN. Freeze is released in this same cycle, so MEM/WB captures the result and the pipeline advances.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with no ready, go to ERR.
- ERR:
  - dmem_req=0, mem_err=1, permanent freeze. Left only by reset.
- Freeze means hold_pc=hold_ifid=hold_idex=hold_exmem=1 and bubble_memwb=1. All other outputs are 0.
- Load-use hazard (evaluated only when not frozen):
  - Condition: ex_ins opcode is 0x23, rt_ex≠0, and id_ins reads rt_ex.
  - Reads-rs: every opcode except j (0x02) and jal (0x03).
  - Reads-rt: opcode 0x00, 0x2B, 0x04, 0x05.
  - Action: hold_pc=1, hold_ifid=1, bubble_idex=1.
- branch_taken (when not frozen): flush_ifid=1, bubble_idex=1, no holds. Branch overrides load-use.
- Priority: reset > ERR/freeze > branch_taken > load-use > normal advance.
- flush_ifid and hold_ifid are never both 1. bubble and hold on the same register are never both 1.

## Timing
- While reset=0 at a clock edge: state←RUN, counter←0, mem_err←0. All outputs read 0 during the reset-low cycle.
- Reset asserted mid-WAIT abandons the access. dmem_req=0 from the reset cycle onward.
- Control outputs are combinational from state and current inputs. No added latency.
- A zero-wait access (ready in the request cycle) costs 0 stall cycles.
- An access whose ready arrives in the Nth cycle after the request costs N stall cycles.
- A load-use hazard costs exactly 1 bubble. The next cycle sees the lw in MEM, not EX, so no second stall is generated.
- branch_taken held during a freeze takes effect in the release cycle.
- dmem_ready in RUN without a memory op is ignored.
- Counter saturation: TIMEOUT=1 goes to ERR on the first WAIT cycle without ready.

## Structure
- Shared package pipe_pkg:
  - Opcode constants OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_LW, OP_SW.
  - State enum {ST_RUN, ST_WAIT, ST_ERR}.
  - Field-slice helper functions for opcode/rs/rt.
- One sub-module, load_use_detect: combinational, inputs id_ins and ex_ins, output hazard.
- The FSM, counter and output priority logic live in the top module.

## Test plan
- sw in mem_ins, dmem_ready=1 in the same cycle → dmem_req=1, dmem_we=1 for one cycle; no hold/bubble asserted; state stays RUN.
- lw in mem_ins, ready after 3 cycles → dmem_req=1, dmem_we=0 for 4 cycles; freeze for 3 cycles; release on the 4th; MEM/WB bubbled 3 times.
- ex_ins = lw $8 (0x8D080000-style, rt=8), id_ins = add $9,$8,$1 → one cycle of hold_pc/hold_ifid/bubble_idex. Same with rt=0 → no stall.
- Load-use and branch_taken together → flush_ifid=1, bubble_idex=1, hold_pc=0.
- TIMEOUT=4, lw with ready never asserted → ERR after 4 WAIT cycles, mem_err=1, dmem_req=0, freeze persists. Then reset=0 for one cycle → all outputs 0, state RUN.
- Reset asserted in the 2nd WAIT cycle → dmem_req=0 from the reset cycle; after release, no stale freeze and counter restarts at 0.
